// File: rtl/reg_renamer.sv
// reg_renamer: register-rename stage between decode and dispatch.
//
// Maps architectural sources through the RAT, allocates a new physical
// destination from a circular free list and presents the renamed instruction
// on a registered valid/ready output. Retire pushes superseded tags back onto
// the free list.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      decoded-instruction handshake
//   in_opcode, in_rs1/rs2/rd architectural fields
//   in_instr                 raw instruction word (passed through)
//   out_valid / out_ready    renamed-instruction handshake
//   out_opcode, out_instr    passed through
//   out_ps1, out_ps2         physical sources
//   out_pd, out_old_pd       new destination and its previous mapping (0 if none)
//   ret_valid, ret_old_pd    retire frees a physical register
//   fl_count                 free-list occupancy
//
// Optional feature, macro RENAME_READY_TABLE_EN: adds a per-tag ready table
// with ports cmp_valid, cmp_pd (writeback broadcast) and out_ps1_rdy,
// out_ps2_rdy (source readiness sampled at accept).

module reg_renamer #(
   parameter int NUM_PREGS = 64,
   parameter int PREG_W    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_opcode,
   output logic [31:0]       out_instr,
   output logic [PREG_W-1:0] out_ps1,
   output logic [PREG_W-1:0] out_ps2,
   output logic [PREG_W-1:0] out_pd,
   output logic [PREG_W-1:0] out_old_pd,
   input  logic              ret_valid,
   input  logic [PREG_W-1:0] ret_old_pd,
`ifdef RENAME_READY_TABLE_EN
   input  logic              cmp_valid,
   input  logic [PREG_W-1:0] cmp_pd,
   output logic              out_ps1_rdy,
   output logic              out_ps2_rdy,
`endif
   output logic [PREG_W:0]   fl_count
);

   localparam int CNT_W = PREG_W + 1;
   localparam int INIT_FREE = NUM_PREGS - 32;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;

   logic [PREG_W-1:0] rat_q [32];
   logic [PREG_W-1:0] rat_d [32];
   logic [PREG_W-1:0] fl_q  [NUM_PREGS];
   logic [PREG_W-1:0] fl_d  [NUM_PREGS];
   logic [PREG_W-1:0] head_q, head_d;
   logic [PREG_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              out_valid_q, out_valid_d;
   logic [6:0]        out_opcode_q, out_opcode_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [PREG_W-1:0] out_ps1_q, out_ps1_d;
   logic [PREG_W-1:0] out_ps2_q, out_ps2_d;
   logic [PREG_W-1:0] out_pd_q, out_pd_d;
   logic [PREG_W-1:0] out_old_pd_q, out_old_pd_d;

   logic              has_dest;
   logic              accept;
   logic              alloc;
   logic              free;
   logic [PREG_W-1:0] alloc_pd;
   logic [PREG_W-1:0] src1;
   logic [PREG_W-1:0] src2;

`ifdef RENAME_READY_TABLE_EN
   logic [NUM_PREGS-1:0] rdy_q, rdy_d;
   logic                 out_ps1_rdy_q, out_ps1_rdy_d;
   logic                 out_ps2_rdy_q, out_ps2_rdy_d;
   logic                 src1_rdy, src2_rdy;
`endif

   // Stalls on an empty list even for non-allocating instructions, which keeps
   // in_rd off the in_ready path.
   always_comb begin
      in_ready = (!out_valid_q || out_ready) && (count_q != '0);
      has_dest = ((in_opcode == OP_R) || (in_opcode == OP_I) || (in_opcode == OP_LD))
                 && (in_rd != 5'd0);
      accept   = in_valid && in_ready;
      alloc    = accept && has_dest;
      alloc_pd = fl_q[head_q];
      src1     = (in_rs1 == 5'd0) ? '0 : rat_q[in_rs1];
      src2     = (in_rs2 == 5'd0) ? '0 : rat_q[in_rs2];
      // A full list cannot take another tag; the retire is dropped.
      free     = ret_valid && (ret_old_pd != '0) && (count_q != CNT_W'(NUM_PREGS));
   end

   always_comb begin
      rat_d   = rat_q;
      fl_d    = fl_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (alloc) begin
         rat_d[in_rd] = alloc_pd;
         head_d       = head_q + PREG_W'(1);
      end
      if (free) begin
         fl_d[tail_q] = ret_old_pd;
         tail_d       = tail_q + PREG_W'(1);
      end
      count_d = count_q + CNT_W'(free) - CNT_W'(alloc);
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_instr_d  = out_instr_q;
      out_ps1_d    = out_ps1_q;
      out_ps2_d    = out_ps2_q;
      out_pd_d     = out_pd_q;
      out_old_pd_d = out_old_pd_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_opcode_d = in_opcode;
         out_instr_d  = in_instr;
         out_ps1_d    = src1;
         out_ps2_d    = src2;
         out_pd_d     = has_dest ? alloc_pd : '0;
         out_old_pd_d = has_dest ? rat_q[in_rd] : '0;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
         out_opcode_d = '0;
         out_instr_d  = '0;
         out_ps1_d    = '0;
         out_ps2_d    = '0;
         out_pd_d     = '0;
         out_old_pd_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rat_q[i] <= PREG_W'(i);
         for (int i = 0; i < NUM_PREGS; i++)
            fl_q[i] <= (i < INIT_FREE) ? PREG_W'(i + 32) : '0;
         head_q       <= '0;
         tail_q       <= PREG_W'(INIT_FREE);
         count_q      <= CNT_W'(INIT_FREE);
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_instr_q  <= '0;
         out_ps1_q    <= '0;
         out_ps2_q    <= '0;
         out_pd_q     <= '0;
         out_old_pd_q <= '0;
      end else begin
         rat_q        <= rat_d;
         fl_q         <= fl_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_opcode_q <= out_opcode_d;
         out_instr_q  <= out_instr_d;
         out_ps1_q    <= out_ps1_d;
         out_ps2_q    <= out_ps2_d;
         out_pd_q     <= out_pd_d;
         out_old_pd_q <= out_old_pd_d;
      end
   end

`ifdef RENAME_READY_TABLE_EN
   // A completion broadcast in the accept cycle is forwarded to the sources.
   always_comb begin
      src1_rdy = (src1 == '0) || rdy_q[src1] || (cmp_valid && (cmp_pd == src1));
      src2_rdy = (src2 == '0) || rdy_q[src2] || (cmp_valid && (cmp_pd == src2));
      rdy_d = rdy_q;
      if (cmp_valid) rdy_d[cmp_pd] = 1'b1;
      // Clear after set so a same-tag collision leaves the tag busy.
      if (alloc) rdy_d[alloc_pd] = 1'b0;
      rdy_d[0] = 1'b1;
      out_ps1_rdy_d = out_ps1_rdy_q;
      out_ps2_rdy_d = out_ps2_rdy_q;
      if (accept) begin
         out_ps1_rdy_d = src1_rdy;
         out_ps2_rdy_d = src2_rdy;
      end else if (out_ready) begin
         out_ps1_rdy_d = 1'b0;
         out_ps2_rdy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q         <= '1;
         out_ps1_rdy_q <= 1'b0;
         out_ps2_rdy_q <= 1'b0;
      end else begin
         rdy_q         <= rdy_d;
         out_ps1_rdy_q <= out_ps1_rdy_d;
         out_ps2_rdy_q <= out_ps2_rdy_d;
      end
   end

   assign out_ps1_rdy = out_ps1_rdy_q;
   assign out_ps2_rdy = out_ps2_rdy_q;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && ret_valid && (ret_old_pd != '0) && (count_q == CNT_W'(NUM_PREGS)))
         $error("reg_renamer: retire of p%0d into a full free list dropped", ret_old_pd);
   end
`endif

   assign out_valid  = out_valid_q;
   assign out_opcode = out_opcode_q;
   assign out_instr  = out_instr_q;
   assign out_ps1    = out_ps1_q;
   assign out_ps2    = out_ps2_q;
   assign out_pd     = out_pd_q;
   assign out_old_pd = out_old_pd_q;
   assign fl_count   = count_q;

endmodule

// File: doc/reg_renamer.md
# reg_renamer

Register-rename stage of the out-of-order RV32I pipeline. It sits between decode and dispatch. It takes one decoded instruction per cycle (opcode, rs1, rs2, rd, raw instruction word) and maps architectural registers to physical registers through the RAT. It allocates a fresh physical destination from a FIFO free list and hands the renamed instruction to dispatch through a registered valid/ready output. Retire returns superseded physical registers to the free list.

## Interface
- NUM_PREGS, 64, physical register count (power of two, >32)
- PREG_W, 6, physical tag width, log2(NUM_PREGS)
---
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_opcode  in  7  instr[6:0]
- in_rs1 / in_rs2 / in_rd  in  5 each  architectural fields
- in_instr  in  32  raw instruction word, passed through
- out_valid  out  1  renamed instruction held
- out_ready  in  1  dispatch accepts
- out_opcode  out  7, out_instr  out  32  passed through
- out_ps1 / out_ps2  out  PREG_W  physical sources
- out_pd  out  PREG_W  new physical destination (0 if none)
- out_old_pd  out  PREG_W  previous mapping of rd (for ROB; 0 if none)
- ret_valid  in  1  retire frees a physical register
- ret_old_pd  in  PREG_W  register to free
- fl_count  out  PREG_W+1  free-list occupancy

## Operation
- Reset state: RAT[i]=i for i=0..31. Free list holds p32..p(NUM_PREGS-1) in ascending order, with head=0, tail=NUM_PREGS-32 and count=NUM_PREGS-32. All outputs are 0 except fl_count=NUM_PREGS-32.
- Destination exists when opcode is 0110011, 0010011 or 0000011 and rd!=0. SW (0100011) and rd=x0 do not allocate, and give pd=0 and old_pd=0.
- Sources: ps1=RAT[rs1] and ps2=RAT[rs2], read before this instruction's own RAT update (rs==rd gets the old mapping). rs=x0 always gives p0. ADDI/ANDI/LW still output ps2=RAT[instr[24:20]]; dispatch ignores it.
- Accept (in_valid && in_ready), with allocation:
  - pd = free-list head entry.
  - old_pd = RAT[rd].
  - RAT[rd] <= pd.
  - Head advances and count decrements.
- Output register is loaded on accept. It is cleared (out_valid=0) when out_ready=1 and no new accept occurs.
- Retire: when ret_valid && ret_old_pd!=0, write ret_old_pd at tail, advance tail and increment count. ret_old_pd=0 is ignored. Retire when count==NUM_PREGS is a protocol error: it is dropped, with a simulation $error.
- Head and tail are PREG_W bits and wrap modulo NUM_PREGS.
- Allocation and free in the same cycle: count is unchanged. A register freed in cycle N is not allocatable before cycle N+1 (no bypass).

## Timing
- in_ready = (!out_valid || out_ready) && (fl_count != 0). The rule is conservative: it stalls on an empty list even for non-allocating instructions. There is no combinational path from in_rd.
- Latency: an instruction accepted at edge N is visible on the out_* ports after edge N. Sustained throughput is 1 per cycle.
- The RAT update is visible to the instruction accepted at edge N+1, so back-to-back dependencies rename correctly.
- While out_valid=1 and out_ready=0, all out_* fields hold stable.
- rst asserted mid-operation immediately restores the reset state. Any in-flight output is dropped.

## Configuration
- RENAME_READY_TABLE_EN defined:
  - Adds a NUM_PREGS-bit ready table.
  - Adds ports: cmp_valid in 1 and cmp_pd in PREG_W (writeback broadcast); out_ps1_rdy out 1 and out_ps2_rdy out 1.
  - Reset sets every bit to 1.
  - Allocation clears ready[pd]. cmp_valid sets ready[cmp_pd]. If both target the same tag in one cycle, clear wins.
  - Source ready is sampled at accept, with same-cycle forwarding: if cmp_pd equals a source tag, that source is reported ready.
  - p0 is always ready.
- Undefined: the table and these ports are absent. Dispatch tracks readiness itself.

## Test plan
- Reset, then ADD x3,x1,x2: out_ps1=1, out_ps2=2, out_pd=32, out_old_pd=3, fl_count=31.
- ADD x3,x1,x2 then SUB x4,x3,x3 back-to-back: second gives ps1=ps2=32, pd=33, old_pd=4.
- SW x5,0(x6) and ADDI x0,x1,1: pd=0, old_pd=0, fl_count unchanged, RAT unchanged.
- 32 allocating ADDIs with no retire: fl_count reaches 0 and in_ready drops. A retire of p7 raises in_ready next cycle. The next ADDI gets pd=7. Tail wraps past index 63 correctly on subsequent frees.
- Hold out_ready=0 for 3 cycles: out_* stable, in_ready=0, no RAT change. Same-cycle alloc and retire keeps fl_count constant.
- With RENAME_READY_TABLE_EN: ADD x3 (pd=32), then ADD x4,x3,x1 gives ps1_rdy=0 and ps2_rdy=1. A cmp_pd=32 in the same cycle as a later accept of a reader of x3 gives ps1_rdy=1.
